dnn_result_collector: RTL and testbench
=======================================

// Module: dnn_result_collector
// PURPOSE
// - Sink end of the dnn_top output interface: captures out0/out1 on their ready strobes.
// - Pairs the two results of one inference, even when the strobes land in different cycles.
// - Buffers pairs in a FIFO and classifies each pair (argmax).
// - Streams {out0, out1, class} downstream over a valid/ready handshake; flags overruns and drops.
// PARAMETERS
// DATA_W   19  signed width of out0/out1 (5b x 5b products, two 4-term accumulation layers)
// DEPTH    4   FIFO depth in result pairs; power of 2, >= 2
// CNT_W    8   width of drop_cnt (saturating)
// PORTS
// clk          in   1                  rising-edge clock
// rst_n        in   1                  async active-low reset
// out0         in   DATA_W             signed result 0 from dnn_top
// out0_ready   in   1                  out0 valid this cycle (single-cycle strobe)
// out1         in   DATA_W             signed result 1 from dnn_top
// out1_ready   in   1                  out1 valid this cycle (single-cycle strobe)
// res_valid    out  1                  FIFO head valid
// res_ready    in   1                  downstream accepts head
// res_out0     out  DATA_W             head result 0
// res_out1     out  DATA_W             head result 1
// res_class    out  1                  1 if res_out1 > res_out0 (signed), else 0
// fifo_count   out  $clog2(DEPTH)+1    stored pairs
// err_clr      in   1                  clears err_overrun, err_drop and drop_cnt
// err_overrun  out  1                  sticky: an output re-strobed before its pair completed
// err_drop     out  1                  sticky: a completed pair was lost to a full FIFO
// drop_cnt     out  CNT_W              number of dropped pairs, saturating at all-ones
// BEHAVIOUR
// - Reset: FIFO empty, both hold flags 0, all outputs 0 (res_* = 0, fifo_count = 0, errors = 0).
// - Reset is async assert, sync deassert. Assertion mid-operation discards held halves and FIFO contents.
// - Pairing: hold registers h0/h1, each with a flag f0/f1.
//   - A strobe loads its hold and sets its flag.
//   - The pair completes in the cycle where, after this cycle's strobes, both halves are available.
//     This covers: both strobes in the same cycle; or one strobe while the other flag is set.
//   - On completion, the pair is pushed at the next edge and both flags clear. Latency: strobe -> res_valid = 1 cycle when empty.
//   - A strobe for a half whose flag is already set, and whose partner is absent:
//     the new value overwrites the hold, err_overrun is set, and no push occurs.
// - Class: computed at push time and stored with the pair.
//   - res_class = ($signed(out1) > $signed(out0)).
//   - Tie gives 0.
// - FIFO: circular, pointers wrap mod DEPTH; extra pointer bit distinguishes full from empty.
//   - Pop when res_valid && res_ready.
//   - Push while full, with no pop in the same cycle: pair discarded, err_drop set, drop_cnt += 1 (saturates).
//   - Push while full with a simultaneous pop: both succeed; count unchanged.
//   - Push while empty: data not visible until the next cycle (no fall-through).
// - Handshake: once res_valid is high, res_out0, res_out1 and res_class hold stable until accepted.
// - err_clr: wins over a same-cycle error event, which is then lost; no effect on FIFO or hold flags.
// CONFIGURATION
// - DNN_COLLECT_RELU_EN defined:
//   - Each captured value is clamped to 0 if negative, at hold-register load.
//   - Stored values, res_out* and class all use the clamped values. Two negatives give a tie: class 0.
// - Undefined: raw signed values are stored and compared; no clamp logic is present.
// TESTING
// 1. Same-cycle strobes out0=100, out1=-5 -> next cycle res_valid=1, res_out0=100, res_out1=-5, res_class=0, fifo_count=1.
// 2. out1=7 strobed cycle N, out0=3 strobed cycle N+3 -> single push; res_class=1; err_overrun=0.
// 3. out0=1, then out0=2 before any out1, then out1=9 -> err_overrun=1; pushed pair (2,9).
// 4. res_ready=0; push DEPTH+2 pairs -> fifo_count=DEPTH, err_drop=1, drop_cnt=2.
//    Then err_clr=1 -> all error outputs 0.
// 5. FIFO full, push and pop in the same cycle -> fifo_count stays DEPTH, no drop, FIFO order preserved across wrap.
// 6. Assert rst_n=0 with FIFO non-empty and f0 set -> all outputs 0 asynchronously.
//    Later out1 strobe alone -> no push.
//    With DNN_COLLECT_RELU_EN: (-4,-9) -> res_out0=0, res_out1=0, res_class=0.

Source files
------------

// File: rtl/dnn_result_collector_if.sv
// Result-collector bus: dnn_top result strobes in, buffered result stream
// and error/status out.
//   slave  : collector side (consumes out0/out1 strobes, produces res_* stream)
//   master : environment side (dnn_top plus downstream consumer)
// Signals:
//   out0/out0_ready, out1/out1_ready : results and single-cycle valid strobes
//   res_valid/res_ready              : downstream handshake
//   res_out0/res_out1/res_class      : FIFO head pair and its argmax
//   fifo_count                       : stored pairs
//   err_clr/err_overrun/err_drop/drop_cnt : error status and clear
interface dnn_result_collector_if #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] out0;
    logic              out0_ready;
    logic [DATA_W-1:0] out1;
    logic              out1_ready;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_out0;
    logic [DATA_W-1:0] res_out1;
    logic              res_class;
    logic [CW-1:0]     fifo_count;
    logic              err_clr;
    logic              err_overrun;
    logic              err_drop;
    logic [CNT_W-1:0]  drop_cnt;

    modport slave (
        input  out0, out0_ready, out1, out1_ready, res_ready, err_clr,
        output res_valid, res_out0, res_out1, res_class, fifo_count,
               err_overrun, err_drop, drop_cnt
    );

    modport master (
        output out0, out0_ready, out1, out1_ready, res_ready, err_clr,
        input  res_valid, res_out0, res_out1, res_class, fifo_count,
               err_overrun, err_drop, drop_cnt
    );
endinterface

// File: rtl/dnn_result_collector.sv
// dnn_result_collector: sink for the dnn_top result strobes. Pairs out0/out1
// of one inference (strobes may arrive in different cycles), classifies the
// pair (res_class = out1 > out0, signed), buffers pairs in a DEPTH-entry FIFO
// and streams them out over res_valid/res_ready. Flags re-strobe overruns and
// pairs dropped on a full FIFO.
// Ports:
//   clk, rst_n : clock, async active-low reset (synchronously released)
//   bus_io     : dnn_result_collector_if.slave (see interface for signals)
// Build option:
//   DNN_COLLECT_RELU_EN : clamp negative captured values to 0 at hold load.
module dnn_result_collector #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dnn_result_collector_if.slave bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef struct packed {
        data_t r0;
        data_t r1;
        logic  cls;
    } entry_t;

    function automatic data_t clamp(data_t x);
`ifdef DNN_COLLECT_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Hold registers and their "half available" flags
    data_t h0_q, h0_d, h1_q, h1_d;
    logic  f0_q, f0_d, f1_q, f1_d;

    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic              ovr_q, ovr_d, drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    data_t  c0, c1, p0, p1;
    logic   avail0, avail1, complete, overrun;
    logic   empty, full, pop, wr_en, drop;
    entry_t head;

    always_comb begin
        c0 = clamp(bus_io.out0);
        c1 = clamp(bus_io.out1);

        // A half is available if strobed now or already held
        avail0   = bus_io.out0_ready | f0_q;
        avail1   = bus_io.out1_ready | f1_q;
        complete = avail0 & avail1;
        // Re-strobe of a held half with no partner: overwrite and flag
        overrun  = (bus_io.out0_ready & f0_q & ~avail1) |
                   (bus_io.out1_ready & f1_q & ~avail0);

        // This cycle's strobe takes precedence over the held value
        p0 = bus_io.out0_ready ? c0 : h0_q;
        p1 = bus_io.out1_ready ? c1 : h1_q;

        h0_d = p0;
        h1_d = p1;
        f0_d = complete ? 1'b0 : avail0;
        f1_d = complete ? 1'b0 : avail1;

        empty = (wr_q == rd_q);
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop   = ~empty & bus_io.res_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        wr_en = complete & (~full | pop);
        drop  = complete & full & ~pop;

        wr_d = wr_q + PW'(wr_en);
        rd_d = rd_q + PW'(pop);

        // Clear wins; a same-cycle error event is lost
        ovr_d  = bus_io.err_clr ? 1'b0 : (ovr_q | overrun);
        drop_d = bus_io.err_clr ? 1'b0 : (drop_q | drop);
        cnt_d  = cnt_q;
        if (bus_io.err_clr) begin
            cnt_d = '0;
        end else if (drop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_q   <= '0;
            h1_q   <= '0;
            f0_q   <= 1'b0;
            f1_q   <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            ovr_q  <= 1'b0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            h0_q   <= h0_d;
            h1_q   <= h1_d;
            f0_q   <= f0_d;
            f1_q   <= f1_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ovr_q  <= ovr_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= '{r0: p0, r1: p1, cls: ($signed(p1) > $signed(p0))};
            end
        end
    end

    // Head is forced to 0 while empty so stale popped entries never show
    always_comb begin
        head                = empty ? '0 : mem_q[rd_q[AW-1:0]];
        bus_io.res_valid    = ~empty;
        bus_io.res_out0     = head.r0;
        bus_io.res_out1     = head.r1;
        bus_io.res_class    = head.cls;
        bus_io.fifo_count   = wr_q - rd_q;
        bus_io.err_overrun  = ovr_q;
        bus_io.err_drop     = drop_q;
        bus_io.drop_cnt     = cnt_q;
    end
endmodule

// File: tb/tb_dnn_result_collector.sv
module tb_dnn_result_collector;
    localparam int unsigned DW = 19;
    localparam int unsigned DP = 4;
    localparam int unsigned CN = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dnn_result_collector_if #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CN)) bus ();

    dnn_result_collector #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int o0r; int o0; int o1r; int o1; int rdy; int clr;
        int ev;  int e0; int e1;  int ec; int ecnt; int eovr; int edrop; int edc;
    } vec_t;

    vec_t vecs[$];

    // Expected stored value for a raw captured input
    function automatic int rv(int x);
`ifdef DNN_COLLECT_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int ev, int e0, int e1, int ec, int ecnt,
                           int eovr, int edrop, int edc);
        logic [DW-1:0] t0;
        logic [DW-1:0] t1;
        t0 = DW'(rv(e0));
        t1 = DW'(rv(e1));
        chk({tag, ".res_valid"},   32'(bus.res_valid),   32'(ev));
        chk({tag, ".res_out0"},    32'(bus.res_out0),    32'(t0));
        chk({tag, ".res_out1"},    32'(bus.res_out1),    32'(t1));
        chk({tag, ".res_class"},   32'(bus.res_class),   32'(ec));
        chk({tag, ".fifo_count"},  32'(bus.fifo_count),  32'(ecnt));
        chk({tag, ".err_overrun"}, 32'(bus.err_overrun), 32'(eovr));
        chk({tag, ".err_drop"},    32'(bus.err_drop),    32'(edrop));
        chk({tag, ".drop_cnt"},    32'(bus.drop_cnt),    32'(edc));
    endtask

    task automatic drive(int o0r, int o0, int o1r, int o1, int rdy, int clr);
        bus.out0_ready = (o0r != 0);
        bus.out0       = DW'(o0);
        bus.out1_ready = (o1r != 0);
        bus.out1       = DW'(o1);
        bus.res_ready  = (rdy != 0);
        bus.err_clr    = (clr != 0);
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cls_neg;
    int d0[4];
    int d1[4];
    int dc[4];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
`ifdef DNN_COLLECT_RELU_EN
        cls_neg = 0;
`else
        cls_neg = 1;
`endif
        //              o0r  o0 o1r  o1 rdy clr | ev  e0  e1  ec cnt ovr drp dc
        vecs.push_back('{1, 100, 1,  -5, 0, 0,   1, 100, -5, 0,  1,  0,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 1, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{0,   0, 1,   7, 0, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 0, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 0, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{1,   3, 0,   0, 0, 0,   1,   3,  7, 1,  1,  0,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 1, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 0, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{1,   1, 0,   0, 0, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{1,   2, 0,   0, 0, 0,   0,   0,  0, 0,  0,  1,  0, 0});
        vecs.push_back('{0,   0, 1,   9, 0, 0,   1,   2,  9, 1,  1,  1,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 1, 1,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{1,   5, 1,   5, 0, 0,   1,   5,  5, 0,  1,  0,  0, 0});
        vecs.push_back('{1,  -8, 1,  -3, 0, 0,   1,   5,  5, 0,  2,  0,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 1, 0,   1,  -8, -3, cls_neg, 1, 0, 0, 0});
        vecs.push_back('{0,   0, 0,   0, 1, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{1,  20, 0,   0, 0, 0,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{1,  21, 0,   0, 0, 1,   0,   0,  0, 0,  0,  0,  0, 0});
        vecs.push_back('{0,   0, 1,  22, 0, 0,   1,  21, 22, 1,  1,  0,  0, 0});
        vecs.push_back('{0,   0, 0,   0, 1, 0,   0,   0,  0, 0,  0,  0,  0, 0});

        #3;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].o0r, vecs[i].o0, vecs[i].o1r, vecs[i].o1, vecs[i].rdy, vecs[i].clr);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].e0, vecs[i].e1, vecs[i].ec,
                    vecs[i].ecnt, vecs[i].eovr, vecs[i].edrop, vecs[i].edc);
        end

        // Overflow: DEPTH+2 pushes with no consumer
        for (int i = 1; i <= DP + 2; i++) begin
            drive(1, i * 10, 1, i * 10 + 1, 0, 0);
            step();
            if (i == DP) chk_all("fill", 1, 10, 11, 1, DP, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk_all("overflow", 1, 10, 11, 1, DP, 0, 1, 2);
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk_all("err_clr", 1, 10, 11, 1, DP, 0, 0, 0);

        // Full FIFO: push and pop in the same cycle, across the pointer wrap
        drive(1, 70, 1, 69, 1, 0);
        step();
        chk_all("fullpp0", 1, 20, 21, 1, DP, 0, 0, 0);
        drive(1, 80, 1, 90, 1, 0);
        step();
        chk_all("fullpp1", 1, 30, 31, 1, DP, 0, 0, 0);
        d0 = '{30, 40, 70, 80};
        d1 = '{31, 41, 69, 90};
        dc = '{1, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk_all($sformatf("drain%0d", k), 1, d0[k], d1[k], dc[k], DP - k, 0, 0, 0);
            drive(0, 0, 0, 0, 1, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk_all("drained", 0, 0, 0, 0, 0, 0, 0, 0);

        // Async reset with FIFO non-empty, f0 held and an error flagged
        drive(1, 1, 1, 2, 0, 0);
        step();
        drive(1, 3, 1, 4, 0, 0);
        step();
        drive(1, 55, 0, 0, 0, 0);
        step();
        drive(1, 56, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk_all("pre_rst", 1, 1, 2, 1, 2, 1, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 1, 9, 0, 0);
        step();
        chk_all("lone_out1", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_all("lone_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 0);
        step();
        chk_all("post_rst", 1, 4, 9, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        step();

        // Two negatives: raw compare gives class 0; clamped values tie at 0
        drive(1, -4, 1, -9, 0, 0);
        step();
        chk_all("neg_pair", 1, -4, -9, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
